// File: rtl/multi_push_sm_pkg.sv
// multi_push_sm_pkg: shared state encoding, CRC-8 polynomial and CRC-8 helper function
package multi_push_sm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        CRC  = 2'd2
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // CRC-8, init 0, MSB-first over the low 'width' bits of data, no reflection, no final XOR
    function automatic logic [7:0] crc8(input logic [63:0] data, input int width);
        logic [7:0] c;
        c = '0;
        for (int i = 63; i >= 0; i--)
            if (i < width)
                c = {c[6:0], 1'b0} ^ ((c[7] ^ data[i]) ? CRC8_POLY : 8'h00);
        return c;
    endfunction

endpackage

// File: rtl/multi_push_sm_if.sv
// multi_push_sm_if: payload input, per-channel push and CRC result handshakes
interface multi_push_sm_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_ready;
    logic [DATA_W-1:0] ch_data;
    logic              crc_valid;
    logic              crc_ready;
    logic [7:0]        crc_out;
    logic              busy;
    logic              skip_err;

    modport master (
        output in_valid, in_data, ch_ready, crc_ready,
        input  in_ready, ch_valid, ch_data, crc_valid, crc_out, busy, skip_err
    );

    modport slave (
        input  in_valid, in_data, ch_ready, crc_ready,
        output in_ready, ch_valid, ch_data, crc_valid, crc_out, busy, skip_err
    );
endinterface

// File: rtl/multi_push_sm_crc8_comb.sv
// crc8_comb: combinational CRC-8 of a DATA_W-bit word
module crc8_comb
    import multi_push_sm_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    output logic [7:0]        crc
);
    assign crc = crc8(64'(data), DATA_W);
endmodule

// File: rtl/multi_push_sm.sv
// multi_push_sm: captures a payload, pushes it to each channel in order, then offers its CRC-8 (optional per-channel timeout: PUSH_SM_TIMEOUT_EN)
module multi_push_sm
    import multi_push_sm_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input logic           clk,
    input logic           rst,
    multi_push_sm_if.slave bus
);
    localparam int IDX_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    state_t            state;
    logic [IDX_W-1:0]  ch_idx;
    logic [NUM_CH-1:0] ch_valid;
    logic [DATA_W-1:0] ch_data;
    logic [7:0]        crc_out;
    logic [7:0]        crc_next;
    logic              in_ready;
    logic              crc_valid;
    logic              busy;
    logic              skip_err;
    logic              adv;
    logic              last;

    crc8_comb #(.DATA_W(DATA_W)) u_crc (
        .data(bus.in_data),
        .crc (crc_next)
    );

    assign last = ch_idx == IDX_W'(NUM_CH - 1);

`ifdef PUSH_SM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             expired;

    assign expired = cnt == CNT_W'(TIMEOUT - 1);
    assign adv     = bus.ch_ready[ch_idx] | expired;

    // per-channel cycle counter; a channel that never accepts is skipped and flagged stickily
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            skip_err <= 1'b0;
        end else if (state == PUSH) begin
            cnt <= adv ? '0 : cnt + 1'b1;
            if (expired && !bus.ch_ready[ch_idx])
                skip_err <= 1'b1;
        end else begin
            cnt <= '0;
        end
    end
`else
    assign adv      = bus.ch_ready[ch_idx];
    assign skip_err = 1'b0;
`endif

    // state machine with registered handshake outputs; ch_valid is a one-hot that shifts per accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch_idx    <= '0;
            ch_data   <= '0;
            crc_out   <= '0;
            ch_valid  <= '0;
            crc_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    state    <= PUSH;
                    ch_idx   <= '0;
                    ch_data  <= bus.in_data;
                    crc_out  <= crc_next;
                    ch_valid <= NUM_CH'(1);
                    busy     <= 1'b1;
                    in_ready <= 1'b0;
                end
                PUSH: if (adv) begin
                    if (last) begin
                        state     <= CRC;
                        ch_valid  <= '0;
                        crc_valid <= 1'b1;
                    end else begin
                        ch_idx   <= ch_idx + 1'b1;
                        ch_valid <= ch_valid << 1;
                    end
                end
                CRC: if (bus.crc_ready) begin
                    state     <= IDLE;
                    crc_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    ch_idx    <= '0;
                    ch_valid  <= '0;
                    crc_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.ch_valid  = ch_valid;
    assign bus.ch_data   = ch_data;
    assign bus.crc_valid = crc_valid;
    assign bus.crc_out   = crc_out;
    assign bus.busy      = busy;
    assign bus.skip_err  = skip_err;

endmodule

// File: tb/tb_multi_push_sm.sv
// tb_multi_push_sm: directed checks of a 2-channel and a 4-channel multi_push_sm (timeout path under PUSH_SM_TIMEOUT_EN)
module tb_multi_push_sm;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    multi_push_sm_if #(.NUM_CH(2), .DATA_W(8)) if2 ();
    multi_push_sm_if #(.NUM_CH(4), .DATA_W(8)) if4 ();

    multi_push_sm #(.NUM_CH(2), .DATA_W(8), .TIMEOUT(16)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    multi_push_sm #(.NUM_CH(4), .DATA_W(8), .TIMEOUT(16)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (if2.ch_valid !== 2'b00) begin errors++; $display("FAIL reset_ch_valid got %b exp 00", if2.ch_valid); end
        checks++; if (if2.crc_valid !== 1'b0) begin errors++; $display("FAIL reset_crc_valid got %b exp 0", if2.crc_valid); end
        checks++; if (if2.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", if2.busy); end
        checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", if2.in_ready); end
        checks++; if (if2.skip_err !== 1'b0) begin errors++; $display("FAIL reset_skip_err got %b exp 0", if2.skip_err); end
        checks++; if (if2.ch_data !== 8'h00) begin errors++; $display("FAIL reset_ch_data got %h exp 00", if2.ch_data); end
        checks++; if (if2.crc_out !== 8'h00) begin errors++; $display("FAIL reset_crc_out got %h exp 00", if2.crc_out); end
        checks++; if (if4.ch_valid !== 4'b0000) begin errors++; $display("FAIL reset4_ch_valid got %b exp 0000", if4.ch_valid); end
        checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL reset4_in_ready got %b exp 1", if4.in_ready); end
    endtask

    task automatic test_basic;
        logic [1:0] exp_v [3];
        exp_v = '{2'b01, 2'b10, 2'b00};
        if2.ch_ready = 2'b11;
        if2.in_data  = 8'h01;
        if2.in_valid = 1'b1;
        @(negedge clk);
        if2.in_valid = 1'b0;
        checks++; if (if2.ch_data !== 8'h01) begin errors++; $display("FAIL basic_ch_data got %h exp 01", if2.ch_data); end
        checks++; if (if2.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready got %b exp 0", if2.in_ready); end
        checks++; if (if2.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", if2.busy); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (if2.ch_valid !== exp_v[i]) begin errors++; $display("FAIL basic_ch_valid[%0d] got %b exp %b", i, if2.ch_valid, exp_v[i]); end
            checks++; if (if2.crc_valid !== (i == 2)) begin errors++; $display("FAIL basic_crc_valid[%0d] got %b exp %b", i, if2.crc_valid, i == 2); end
            if (i < 2) @(negedge clk);
        end
        checks++; if (if2.crc_out !== 8'h07) begin errors++; $display("FAIL basic_crc_out got %h exp 07", if2.crc_out); end
        if2.crc_ready = 1'b1;
        @(negedge clk);
        if2.crc_ready = 1'b0;
        checks++; if (if2.crc_valid !== 1'b0) begin errors++; $display("FAIL basic_crc_drop got %b exp 0", if2.crc_valid); end
        checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready got %b exp 1", if2.in_ready); end
        checks++; if (if2.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b exp 0", if2.busy); end
    endtask

    task automatic test_crc_hold;
        if2.ch_ready  = 2'b11;
        if2.crc_ready = 1'b0;
        if2.in_data   = 8'hFF;
        if2.in_valid  = 1'b1;
        @(negedge clk);
        if2.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++; if (if2.crc_valid !== 1'b1) begin errors++; $display("FAIL hold_crc_valid[%0d] got %b exp 1", i, if2.crc_valid); end
            checks++; if (if2.crc_out !== 8'hF3) begin errors++; $display("FAIL hold_crc_out[%0d] got %h exp f3", i, if2.crc_out); end
            if (i == 4) if2.crc_ready = 1'b1;
            @(negedge clk);
        end
        if2.crc_ready = 1'b0;
        checks++; if (if2.crc_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b exp 0", if2.crc_valid); end
        checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL hold_idle got %b exp 1", if2.in_ready); end
    endtask

    task automatic test_order4;
        logic [3:0] exp_v [7];
        logic [3:0] rdy   [7];
        exp_v = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
        rdy   = '{4'b1001, 4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b1100, 4'b1000};
        if4.in_data  = 8'h01;
        if4.in_valid = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checks++; if (if4.ch_valid !== exp_v[i]) begin errors++; $display("FAIL order4_ch_valid[%0d] got %b exp %b", i, if4.ch_valid, exp_v[i]); end
            if4.ch_ready = rdy[i];
            @(negedge clk);
        end
        if4.ch_ready = 4'b0000;
        checks++; if (if4.ch_valid !== 4'b0000) begin errors++; $display("FAIL order4_done got %b exp 0000", if4.ch_valid); end
        checks++; if (if4.crc_valid !== 1'b1) begin errors++; $display("FAIL order4_crc_valid got %b exp 1", if4.crc_valid); end
        checks++; if (if4.crc_out !== 8'h07) begin errors++; $display("FAIL order4_crc_out got %h exp 07", if4.crc_out); end
        if4.crc_ready = 1'b1;
        @(negedge clk);
        if4.crc_ready = 1'b0;
        checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL order4_idle got %b exp 0", if4.busy); end
    endtask

    task automatic test_reset_mid;
        if2.ch_ready = 2'b01;
        if2.in_data  = 8'h5A;
        if2.in_valid = 1'b1;
        @(negedge clk);
        if2.in_valid = 1'b0;
        checks++; if (if2.ch_valid !== 2'b01) begin errors++; $display("FAIL mid_ch0 got %b exp 01", if2.ch_valid); end
        @(negedge clk);
        checks++; if (if2.ch_valid !== 2'b10) begin errors++; $display("FAIL mid_ch1 got %b exp 10", if2.ch_valid); end
        if2.ch_ready = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if2.ch_ready = 2'b11;
        checks++; if (if2.ch_data !== 8'h00) begin errors++; $display("FAIL mid_ch_data got %h exp 00", if2.ch_data); end
        checks++; if (if2.crc_out !== 8'h00) begin errors++; $display("FAIL mid_crc_out got %h exp 00", if2.crc_out); end
        checks++; if (if2.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", if2.busy); end
        checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", if2.in_ready); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (if2.ch_valid !== 2'b00 || if2.crc_valid !== 1'b0) begin errors++; $display("FAIL mid_quiet[%0d] got %b/%b exp 00/0", i, if2.ch_valid, if2.crc_valid); end
            @(negedge clk);
        end
        if2.ch_ready = 2'b00;
    endtask

    task automatic test_back_to_back;
        if2.ch_ready  = 2'b11;
        if2.crc_ready = 1'b1;
        if2.in_data   = 8'h01;
        if2.in_valid  = 1'b1;
        @(negedge clk);
        if2.in_data = 8'hFF;
        repeat (2) @(negedge clk);
        checks++; if (if2.crc_valid !== 1'b1 || if2.crc_out !== 8'h07) begin errors++; $display("FAIL b2b_first got %b/%h exp 1/07", if2.crc_valid, if2.crc_out); end
        @(negedge clk);
        checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b exp 1", if2.in_ready); end
        @(negedge clk);
        if2.in_valid = 1'b0;
        checks++; if (if2.ch_valid !== 2'b01 || if2.ch_data !== 8'hFF) begin errors++; $display("FAIL b2b_second_push got %b/%h exp 01/ff", if2.ch_valid, if2.ch_data); end
        repeat (2) @(negedge clk);
        checks++; if (if2.crc_valid !== 1'b1 || if2.crc_out !== 8'hF3) begin errors++; $display("FAIL b2b_second got %b/%h exp 1/f3", if2.crc_valid, if2.crc_out); end
        @(negedge clk);
        checks++; if (if2.in_ready !== 1'b1 || if2.crc_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b/%b exp 1/0", if2.in_ready, if2.crc_valid); end
        if2.crc_ready = 1'b0;
        if2.ch_ready  = 2'b00;
    endtask

    task automatic test_timeout;
        if2.ch_ready = 2'b00;
        if2.in_data  = 8'h33;
        if2.in_valid = 1'b1;
        @(negedge clk);
        if2.in_valid = 1'b0;
`ifdef PUSH_SM_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            checks++; if (if2.ch_valid !== 2'b01 || if2.skip_err !== 1'b0) begin errors++; $display("FAIL to_wait[%0d] got %b/%b exp 01/0", i, if2.ch_valid, if2.skip_err); end
            @(negedge clk);
        end
        checks++; if (if2.ch_valid !== 2'b10) begin errors++; $display("FAIL to_skip got %b exp 10", if2.ch_valid); end
        checks++; if (if2.skip_err !== 1'b1) begin errors++; $display("FAIL to_skip_err got %b exp 1", if2.skip_err); end
        if2.ch_ready = 2'b10;
        @(negedge clk);
        if2.ch_ready = 2'b00;
        checks++; if (if2.crc_valid !== 1'b1) begin errors++; $display("FAIL to_crc got %b exp 1", if2.crc_valid); end
        if2.crc_ready = 1'b1;
        @(negedge clk);
        if2.crc_ready = 1'b0;
        checks++; if (if2.busy !== 1'b0 || if2.skip_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b/%b exp 0/1", if2.busy, if2.skip_err); end
`else
        for (int i = 0; i < 20; i++) begin
            checks++; if (if2.ch_valid !== 2'b01 || if2.skip_err !== 1'b0) begin errors++; $display("FAIL nto_wait[%0d] got %b/%b exp 01/0", i, if2.ch_valid, if2.skip_err); end
            @(negedge clk);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (if2.skip_err !== 1'b0 || if2.busy !== 1'b0) begin errors++; $display("FAIL to_reset got %b/%b exp 0/0", if2.skip_err, if2.busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        if2.in_valid = 1'b0; if2.in_data = '0; if2.ch_ready = '0; if2.crc_ready = 1'b0;
        if4.in_valid = 1'b0; if4.in_data = '0; if4.ch_ready = '0; if4.crc_ready = 1'b0;
        test_reset();
        test_basic();
        test_crc_hold();
        test_order4();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_push_sm.md
MULTI_PUSH_SM -- requirements
Module: multi_push_sm

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of downstream push channels (legal range 1..16).
REQ-002 SHALL have parameter DATA_W, default 8, payload width in bits (legal range 8..64).
REQ-003 SHALL have parameter TIMEOUT, default 16, cycles allowed per channel push; used only when PUSH_SM_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  new payload offered.
REQ-007 SHALL have port in_ready  output  1  payload accepted when in_valid&in_ready.
REQ-008 SHALL have port in_data  input  DATA_W  payload.
REQ-009 SHALL have port ch_valid  output  NUM_CH  one-hot push request, one bit per channel.
REQ-010 SHALL have port ch_ready  input  NUM_CH  per-channel accept.
REQ-011 SHALL have port ch_data  output  DATA_W  captured payload, shared by all channels.
REQ-012 SHALL have port crc_valid  output  1  CRC result offered.
REQ-013 SHALL have port crc_ready  input  1  CRC result consumed.
REQ-014 SHALL have port crc_out  output  8  CRC-8 of the captured payload.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port skip_err  output  1  sticky flag, set when a channel is skipped on timeout.

Function
REQ-017 SHALL implement states IDLE, PUSH and CRC.
REQ-018 IDLE: in_ready=1; on in_valid, SHALL capture in_data into ch_data, set ch_idx=0 and enter PUSH on the next cycle.
REQ-019 PUSH: ch_valid SHALL have only bit ch_idx set, and ch_data SHALL hold stable.
REQ-020 PUSH: on ch_ready[ch_idx], SHALL advance ch_idx by 1, or, if ch_idx==NUM_CH-1, enter CRC; each channel takes at least 1 cycle.
REQ-021 ch_ready bits other than bit ch_idx SHALL be ignored.
REQ-022 CRC: crc_valid=1 and crc_out SHALL hold stable; on crc_ready, SHALL enter IDLE.
REQ-023 in_ready SHALL be 0 outside IDLE; back-to-back transactions SHALL have a minimum gap of 0 idle cycles after CRC exits.
REQ-024 CRC SHALL be CRC-8: poly 0x07, init 0x00, MSB-first over all DATA_W bits, no reflection, no final XOR.
REQ-025 CRC SHALL be computed combinationally from in_data and registered at capture.
REQ-026 Minimum transaction latency SHALL be 1 (capture) + NUM_CH + 1 (CRC) cycles.
REQ-027 ch_idx SHALL be $clog2(NUM_CH) bits wide, minimum 1 bit; it SHALL never exceed NUM_CH-1.
REQ-028 Any illegal state encoding SHALL return the machine to IDLE on the next cycle.

Reset
REQ-029 While rst=1 at a clock edge, the machine SHALL enter IDLE, with ch_idx=0, ch_data=0, crc_out=0, ch_valid=0, crc_valid=0, busy=0, in_ready=1 (from the cycle after reset) and skip_err=0.
REQ-030 rst asserted mid-PUSH or mid-CRC SHALL abort the transaction, with no further ch_valid or crc_valid pulses.

Configuration
REQ-031 With PUSH_SM_TIMEOUT_EN defined, a counter SHALL count cycles in PUSH on the current channel; at TIMEOUT cycles without ch_ready, the channel SHALL be skipped as if accepted, and skip_err SHALL set.
REQ-032 With PUSH_SM_TIMEOUT_EN defined, skip_err SHALL clear only on rst, and the counter SHALL restart at 0 on every channel advance.
REQ-033 Without PUSH_SM_TIMEOUT_EN, there SHALL be no counter, PUSH SHALL wait indefinitely, and skip_err SHALL be tied to 0.

Structure
REQ-034 Package multi_push_sm_pkg SHALL hold the state_t enum (IDLE, PUSH, CRC), the CRC8_POLY constant (0x07) and the crc8 function.
REQ-035 Sub-module crc8_comb (DATA_W parameter, combinational) SHALL compute the CRC; everything else SHALL live in multi_push_sm.

Verification
REQ-036 NUM_CH=2, DATA_W=8: in_data=0x01, ch_ready tied 1 -> ch_valid 01 then 10 on consecutive cycles, crc_out=0x07, crc_valid on cycle 4.
REQ-037 in_data=0xFF, crc_ready held 0 for 5 cycles -> crc_valid and crc_out=0xF3 held stable for 5 cycles, IDLE on the cycle after crc_ready.
REQ-038 NUM_CH=4: ch_ready[2] delayed 3 cycles, ch_ready[3] asserted early -> bit 3 is ignored, and the push order is strictly 0,1,2,3.
REQ-039 rst pulsed during PUSH at ch_idx=1 -> all outputs reach reset values, and no crc_valid pulse occurs.
REQ-040 With PUSH_SM_TIMEOUT_EN and TIMEOUT=16: ch_ready[0] never asserted -> channel 1 is requested after 16 cycles, skip_err=1 until rst.
REQ-041 Two back-to-back in_valid payloads, 0x01 then 0xFF -> second payload is accepted in IDLE, and crc_out values are 0x07 then 0xF3.
